// File: rtl/msg_loader.sv
// msg_loader: double-buffered character message loader.
// Characters go into a shadow bank; a terminator commits the message by swapping
// the shadow and active banks, so the display side never sees a partial message.
// Optional build macro: MSG_LOADER_UPCASE_EN folds lowercase letters to uppercase on store.
module msg_loader #(
    parameter int MAX_LEN    = 16,
    parameter int CHAR_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [CHAR_WIDTH-1:0]          in_char,
    input  logic [$clog2(MAX_LEN)-1:0]     rd_index,
    output logic [CHAR_WIDTH-1:0]          rd_char,
    output logic [$clog2(MAX_LEN+1)-1:0]   msg_len,
    output logic                           msg_valid,
    output logic                           overflow,
    input  logic                           clear_err
);

    localparam int IDX_W = $clog2(MAX_LEN);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [CHAR_WIDTH-1:0] C_SPACE = CHAR_WIDTH'(8'h20);
    localparam logic [CHAR_WIDTH-1:0] C_TILDE = CHAR_WIDTH'(8'h7E);
    localparam logic [CHAR_WIDTH-1:0] C_CR    = CHAR_WIDTH'(8'h0D);
    localparam logic [CHAR_WIDTH-1:0] C_BS    = CHAR_WIDTH'(8'h08);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_COMMIT,
        S_DROP
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LEN_W-1:0]      r_count;
    logic [LEN_W-1:0]      w_count_nxt;
    logic                  r_active;
    logic                  w_active_nxt;
    logic [LEN_W-1:0]      r_msg_len;
    logic [LEN_W-1:0]      w_len_nxt;
    logic                  r_msg_valid;
    logic                  w_valid_nxt;
    logic                  r_overflow;
    logic                  w_ovf_set;
    logic [CHAR_WIDTH-1:0] r_rd_char;
    logic [CHAR_WIDTH-1:0] w_rd_nxt;
    logic                  w_wr_en;
    logic                  w_accept;
    logic                  w_is_print;
    logic                  w_is_term;
    logic                  w_is_bs;
    logic [CHAR_WIDTH-1:0] w_store_char;

    // Two banks; the one selected by r_active is the display (read) side.
    logic [CHAR_WIDTH-1:0] r_bank [2][MAX_LEN];

    assign in_ready   = (r_state != S_COMMIT);
    assign w_accept   = in_valid && in_ready;
    assign w_is_print = (in_char >= C_SPACE) && (in_char <= C_TILDE);
    assign w_is_term  = (in_char == '0) || (in_char == C_CR);
    assign w_is_bs    = (in_char == C_BS);

`ifdef MSG_LOADER_UPCASE_EN
    // Fold lowercase letters to uppercase before they are stored.
    always_comb begin
        w_store_char = in_char;
        if ((in_char >= CHAR_WIDTH'(8'h61)) && (in_char <= CHAR_WIDTH'(8'h7A)))
            w_store_char = in_char - CHAR_WIDTH'(8'h20);
    end
`else
    assign w_store_char = in_char;
`endif

    // Next-state and datapath control for the load/commit/drop sequence.
    always_comb begin
        w_state_nxt  = r_state;
        w_count_nxt  = r_count;
        w_active_nxt = r_active;
        w_len_nxt    = r_msg_len;
        w_valid_nxt  = r_msg_valid;
        w_wr_en      = 1'b0;
        w_ovf_set    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_print) begin
                    w_wr_en     = 1'b1;
                    w_count_nxt = LEN_W'(1);
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_accept) begin
                    if (w_is_print) begin
                        if (r_count == LEN_W'(MAX_LEN)) begin
                            w_ovf_set   = 1'b1;
                            w_state_nxt = S_DROP;
                        end else begin
                            w_wr_en     = 1'b1;
                            w_count_nxt = r_count + LEN_W'(1);
                        end
                    end else if (w_is_term) begin
                        w_state_nxt = S_COMMIT;
                    end else if (w_is_bs) begin
                        w_count_nxt = r_count - LEN_W'(1);
                        if (r_count == LEN_W'(1))
                            w_state_nxt = S_IDLE;
                    end
                end
            end
            S_COMMIT: begin
                w_active_nxt = ~r_active;
                w_len_nxt    = r_count;
                w_valid_nxt  = 1'b1;
                w_count_nxt  = '0;
                w_state_nxt  = S_IDLE;
            end
            S_DROP: begin
                if (w_accept && w_is_term) begin
                    w_count_nxt = '0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read data is computed from the post-edge bank/length/valid so the new
    // message appears as a whole on the cycle right after the swap.
    always_comb begin
        w_rd_nxt = C_SPACE;
        if (w_valid_nxt && (LEN_W'(rd_index) < w_len_nxt))
            w_rd_nxt = r_bank[w_active_nxt][rd_index];
    end

    // Control state, committed message descriptor, sticky overflow and read register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_active    <= 1'b0;
            r_msg_len   <= '0;
            r_msg_valid <= 1'b0;
            r_overflow  <= 1'b0;
            r_rd_char   <= C_SPACE;
        end else begin
            r_state     <= w_state_nxt;
            r_count     <= w_count_nxt;
            r_active    <= w_active_nxt;
            r_msg_len   <= w_len_nxt;
            r_msg_valid <= w_valid_nxt;
            r_rd_char   <= w_rd_nxt;
            if (w_ovf_set)
                r_overflow <= 1'b1;
            else if (clear_err)
                r_overflow <= 1'b0;
        end
    end

    // Shadow bank write; storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_en)
            r_bank[~r_active][IDX_W'(r_count)] <= w_store_char;
    end

    assign rd_char   = r_rd_char;
    assign msg_len   = r_msg_len;
    assign msg_valid = r_msg_valid;
    assign overflow  = r_overflow;

endmodule

// File: doc/msg_loader.md
MSG_LOADER -- requirements
Module: msg_loader

Interface
REQ-001 Parameter MAX_LEN, default 16: message buffer capacity in characters, 2..64.
REQ-002 Parameter CHAR_WIDTH, default 8: character width in bits (ASCII).
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_char holds a character offered by the source.
REQ-006 in_ready  output  1  loader accepts in_char this cycle; a transfer occurs when in_valid && in_ready.
REQ-007 in_char  input  CHAR_WIDTH  incoming character.
REQ-008 rd_index  input  $clog2(MAX_LEN)  display-side read address into the committed message.
REQ-009 rd_char  output  CHAR_WIDTH  registered committed character at rd_index.
REQ-010 msg_len  output  $clog2(MAX_LEN+1)  length of the committed message.
REQ-011 msg_valid  output  1  at least one message has been committed since reset.
REQ-012 overflow  output  1  sticky: a message exceeded MAX_LEN and was discarded.
REQ-013 clear_err  input  1  synchronous clear of overflow.

Function
REQ-014 Storage SHALL be two banks of MAX_LEN characters: active bank (read side), shadow bank (write side); commit swaps roles.
REQ-015 FSM states SHALL be IDLE, LOAD, COMMIT, DROP.
REQ-016 IDLE: shadow count 0; accepted printable char (0x20..0x7E) written to shadow[0], count=1, go LOAD.
REQ-017 LOAD: accepted printable char written to shadow[count], count+1; if count==MAX_LEN before write, char not written, overflow set, go DROP.
REQ-018 Terminators 0x0D and 0x00 SHALL end a message: in LOAD go COMMIT; in IDLE ignored (empty message never commits); in DROP go IDLE with count cleared.
REQ-019 Backspace 0x08 SHALL decrement count when count>0, go IDLE when count reaches 0; ignored in IDLE and DROP.
REQ-020 All other non-printable characters SHALL be accepted and discarded without state change.
REQ-021 COMMIT lasts exactly one cycle: in_ready=0, active/shadow swap, msg_len=count, msg_valid=1, count=0, next state IDLE.
REQ-022 in_ready SHALL be 1 in IDLE, LOAD, DROP; 0 only in COMMIT.
REQ-023 DROP: all characters accepted and discarded until a terminator; committed message unchanged.
REQ-024 rd_char SHALL equal active[rd_index] one cycle after rd_index is presented; 0x20 (space) if rd_index >= msg_len or msg_valid=0.
REQ-025 rd_char SHALL reflect the new message starting the cycle after COMMIT; no mixed-bank output in any cycle.
REQ-026 overflow set and clear_err in the same cycle: set wins.

Reset
REQ-027 rst_n low SHALL force: state IDLE, count 0, active bank 0, msg_len 0, msg_valid 0, overflow 0, rd_char 0x20; buffer contents not reset.
REQ-028 Reset mid-LOAD or mid-COMMIT SHALL discard the partial message; first post-reset commit behaves as from power-up.

Configuration
REQ-029 Macro MSG_LOADER_UPCASE_EN defined: accepted chars 0x61..0x7A SHALL be stored minus 0x20 (uppercase) for 7-segment legibility.
REQ-030 MSG_LOADER_UPCASE_EN undefined: characters stored unmodified; no folding logic present.

Verification
REQ-031 Send "HELLO",0x0D -> msg_len=5, msg_valid=1, rd_index 0..4 returns H,E,L,L,O; rd_index 5 returns 0x20.
REQ-032 With "HELLO" committed, send "AB" without terminator -> rd_char still from "HELLO"; then 0x0D -> msg_len=2, "AB" visible next cycle, in_ready low exactly one cycle.
REQ-033 MAX_LEN=16: send 17 printable chars then 0x0D -> overflow=1, previous message and msg_len unchanged; clear_err -> overflow=0.
REQ-034 Send "AX",0x08,"B",0x0D -> msg_len=2, message "AB"; send 0x0D alone -> no commit.
REQ-035 Assert rst_n low after "HE" mid-LOAD -> msg_len=0, msg_valid=0, rd_char=0x20; then "12",0x0D commits "12".
REQ-036 With MSG_LOADER_UPCASE_EN: "hi",0x0D -> stored "HI"; without: stored "hi".
